// File: rtl/led_btn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : led_btn_ctrl_if
// Brief   : Button/LED channel bundle between a stimulus source and led_btn_ctrl.
// Rev     : 1.0 - initial release
// ============================================================================
interface led_btn_ctrl_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] btn;
  logic              all_off;
  logic [NUM_CH-1:0] btn_db;
  logic [NUM_CH-1:0] press;
  logic [NUM_CH-1:0] led;

  modport master (
    output btn,
    output all_off,
    input  btn_db,
    input  press,
    input  led
  );

  modport slave (
    input  btn,
    input  all_off,
    output btn_db,
    output press,
    output led
  );
endinterface : led_btn_ctrl_if
`default_nettype wire

// File: rtl/led_btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : led_btn_ctrl
// Brief   : Per-channel button debounce, press detect and OFF/ON(/BLINK) LED mode.
//           Define LED_BLINK_EN to add the BLINK mode and its shared prescaler.
// Rev     : 1.0 - initial release
// ============================================================================
module led_btn_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int DEB_CYCLES = 4,
  parameter int BLINK_DIV  = 8
) (
  input logic           sclk,
  input logic           rstn,
  led_btn_ctrl_if.slave bus
);

  localparam int            CW         = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_e;

  if (NUM_CH < 1 || NUM_CH > 16 || DEB_CYCLES < 1 || BLINK_DIV < 2) begin : g_param_check
    $error("led_btn_ctrl: illegal parameter value");
  end

  logic [NUM_CH-1:0] s1_q;
  logic [NUM_CH-1:0] s2_q;

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.btn;
      s2_q <= s1_q;
    end
  end

  logic blink_phase;

`ifdef LED_BLINK_EN
  localparam int PW = $clog2(BLINK_DIV);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          phase_q;
  logic          phase_d;

  // Free-running: never restarted by mode changes, so all blinking LEDs share phase.
  always_comb begin
    presc_d = presc_q + PW'(1);
    phase_d = phase_q;
    if (presc_q == PW'(BLINK_DIV - 1)) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      presc_q <= '0;
      phase_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase = phase_q;
`else
  assign blink_phase = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          db_q;
    logic          db_d;
    logic          press_q;
    logic          press_d;
    logic          led_q;
    logic          led_d;
    mode_e         mode_q;
    mode_e         mode_d;

    always_comb begin
      cnt_d   = cnt_q;
      db_d    = db_q;
      press_d = 1'b0;
      if (s2_q[i] == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == C_CNT_LAST) begin
        db_d    = s2_q[i];
        cnt_d   = '0;
        press_d = s2_q[i];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // all_off wins over a coincident press, which is dropped rather than deferred.
    always_comb begin
      mode_d = mode_q;
      if (bus.all_off) begin
        mode_d = MODE_OFF;
      end else if (press_q) begin
        case (mode_q)
          MODE_OFF: mode_d = MODE_ON;
`ifdef LED_BLINK_EN
          MODE_ON:  mode_d = MODE_BLINK;
`else
          MODE_ON:  mode_d = MODE_OFF;
`endif
          default:  mode_d = MODE_OFF;
        endcase
      end
    end

    always_comb begin
      led_d = 1'b0;
      case (mode_q)
        MODE_ON:    led_d = 1'b1;
        MODE_BLINK: led_d = blink_phase;
        default:    led_d = 1'b0;
      endcase
    end

    always_ff @(posedge sclk) begin
      if (!rstn) begin
        cnt_q   <= '0;
        db_q    <= 1'b0;
        press_q <= 1'b0;
        led_q   <= 1'b0;
        mode_q  <= MODE_OFF;
      end else begin
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        press_q <= press_d;
        led_q   <= led_d;
        mode_q  <= mode_d;
      end
    end

    assign bus.btn_db[i] = db_q;
    assign bus.press[i]  = press_q;
    assign bus.led[i]    = led_q;
  end

endmodule : led_btn_ctrl
`default_nettype wire

// File: tb/tb_led_btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_btn_ctrl
// Brief   : Scoreboard bench for led_btn_ctrl against a window-based reference.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_led_btn_ctrl;

  localparam int NUM_CH = 4;
  localparam int DEB    = 4;
  localparam int DIV    = 8;
`ifdef LED_BLINK_EN
  localparam int NMODES = 3;
`else
  localparam int NMODES = 2;
`endif

  logic sclk = 1'b0;
  logic rstn = 1'b0;
  always #5 sclk = ~sclk;

  led_btn_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

  led_btn_ctrl #(
    .NUM_CH    (NUM_CH),
    .DEB_CYCLES(DEB),
    .BLINK_DIV (DIV)
  ) dut (
    .sclk(sclk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] pr;
    logic [NUM_CH-1:0] led;
  } exp_t;

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state: synchroniser, last DEB synchronised samples, accepted level,
  // press pulse, mode index (0=OFF,1=ON,2=BLINK), LED and edges since reset.
  logic [NUM_CH-1:0] m_s1, m_s2, m_db, m_pr, m_led;
  logic [DEB-1:0]    m_hist[NUM_CH];
  int                m_mode[NUM_CH];
  int                m_edges;

  task automatic model_edge(input logic [NUM_CH-1:0] b, input logic ao, input logic rn);
    logic [NUM_CH-1:0] db_n, pr_n, led_n;
    logic              load;
    int                ph;
    exp_t              e;
    if (!rn) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_pr = '0; m_led = '0; m_edges = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_hist[c] = '0;
        m_mode[c] = 0;
      end
    end else begin
      ph = (m_edges / DIV) % 2;
      for (int c = 0; c < NUM_CH; c++) begin
        led_n[c] = (m_mode[c] == 0) ? 1'b0 : (m_mode[c] == 1) ? 1'b1 : (ph != 0);
        m_hist[c] = {m_hist[c][DEB-2:0], m_s2[c]};
        // Accept a new level once the last DEB synchronised samples all disagree.
        load     = m_db[c] ? (m_hist[c] == '0) : (&m_hist[c]);
        pr_n[c]  = load & ~m_db[c];
        db_n[c]  = load ? ~m_db[c] : m_db[c];
        if (ao)          m_mode[c] = 0;
        else if (m_pr[c]) m_mode[c] = (m_mode[c] + 1) % NMODES;
      end
      m_edges++;
      m_s2  = m_s1;
      m_s1  = b;
      m_db  = db_n;
      m_pr  = pr_n;
      m_led = led_n;
    end
    e.db  = m_db;
    e.pr  = m_pr;
    e.led = m_led;
    expq.push_back(e);
  endtask

  task automatic step(input logic [NUM_CH-1:0] b, input logic ao, input logic rn);
    @(negedge sclk);
    bus.btn     = b;
    bus.all_off = ao;
    rstn        = rn;
    @(posedge sclk);
    model_edge(b, ao, rn);
  endtask

  task automatic chk(input string name, input logic [NUM_CH-1:0] got, input logic [NUM_CH-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sclk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("btn_db", bus.btn_db, e.db);
        chk("press",  bus.press,  e.pr);
        chk("led",    bus.led,    e.led);
      end
    end
  end

  initial begin : driver
    logic [NUM_CH-1:0] b;
    int                hold[NUM_CH];
    int                rst_left;
    b           = '0;
    bus.btn     = '0;
    bus.all_off = 1'b0;
    rstn        = 1'b0;

    repeat (3) step(b, 1'b0, 1'b0);

    // Held press on ch0, then a too-short glitch on ch1.
    b[0] = 1'b1; repeat (10) step(b, 1'b0, 1'b1);
    b[1] = 1'b1; repeat (3)  step(b, 1'b0, 1'b1);
    b[1] = 1'b0; repeat (10) step(b, 1'b0, 1'b1);

    // ch3 to ON, then all_off coinciding with the next press pulse.
    b[3] = 1'b1; repeat (6) step(b, 1'b0, 1'b1);
    b[3] = 1'b0; repeat (6) step(b, 1'b0, 1'b1);
    b[3] = 1'b1;
    for (int j = 0; j < 10; j++) step(b, (j == 6), 1'b1);
    b[3] = 1'b0; repeat (8) step(b, 1'b0, 1'b1);

    // Three presses on ch2 with long gaps to observe blinking.
    repeat (3) begin
      b[2] = 1'b1; repeat (8)  step(b, 1'b0, 1'b1);
      b[2] = 1'b0; repeat (40) step(b, 1'b0, 1'b1);
    end

    // Advance ch0 once more, then reset with btn[0] held.
    b[0] = 1'b0; repeat (8) step(b, 1'b0, 1'b1);
    b[0] = 1'b1; repeat (8) step(b, 1'b0, 1'b1);
    repeat (2)  step(b, 1'b0, 1'b0);
    repeat (12) step(b, 1'b0, 1'b1);

    for (int c = 0; c < NUM_CH; c++) hold[c] = 0;
    rst_left = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hold[c] == 0) begin
          b[c]    = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 12));
        end else begin
          hold[c]--;
        end
      end
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = 2;
      step(b, ($urandom_range(0, 99) == 0), (rst_left == 0));
      if (rst_left > 0) rst_left--;
    end

    repeat (3) @(negedge sclk);
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_led_btn_ctrl
`default_nettype wire

// File: doc/led_btn_ctrl.md
LED_BTN_CTRL -- requirements
Module: led_btn_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of button/LED channels; legal range 1..16.
REQ-002 Parameter DEB_CYCLES, default 4: consecutive stable cycles required to accept a new button level; minimum 1.
REQ-003 Parameter BLINK_DIV, default 8: cycles per blink half-period; minimum 2.
REQ-004 sclk  input  1  sole clock; all logic is rising-edge.
REQ-005 rstn  input  1  reset; synchronous, active-low.
REQ-006 btn  input  NUM_CH  raw asynchronous push-buttons; 1 = pressed.
REQ-007 all_off  input  1  synchronous clear; forces every channel's mode to OFF.
REQ-008 btn_db  output  NUM_CH  debounced button level per channel.
REQ-009 press  output  NUM_CH  one-cycle pulse per accepted press (debounced 0->1).
REQ-010 led  output  NUM_CH  LED drive per channel; 1 = lit.

Function
REQ-011 Each btn bit passes through a 2-flop synchroniser (s1, s2) before any other use.
REQ-012 Per channel, a debounce counter of width $clog2(DEB_CYCLES+1) clears when s2 equals btn_db, else increments by 1.
REQ-013 When s2 differs from btn_db and the counter equals DEB_CYCLES-1, btn_db loads s2 and the counter clears on the same edge.
REQ-014 press[i] is registered and high for exactly the one cycle after the edge where btn_db[i] goes 0->1; it never asserts on release.
REQ-015 Latency: btn change sampled at edge k gives btn_db/press at the output after edge k+1+DEB_CYCLES.
REQ-016 A level change lasting fewer than DEB_CYCLES cycles at s2 produces no change on btn_db and no press.
REQ-017 Per-channel mode register with states OFF, ON, BLINK; each cycle with press[i]=1 advances it one step (sequence in REQ-025/026).
REQ-018 all_off=1 sets every mode to OFF on that edge; it takes priority over a simultaneous press, and that press is discarded.
REQ-019 Channels are independent; simultaneous presses on several channels each advance their own mode on the same edge.
REQ-020 A shared blink prescaler counts 0..BLINK_DIV-1 and wraps; blink_phase toggles on each wrap; both run freely regardless of mode.
REQ-021 led is registered: OFF->0, ON->1, BLINK->blink_phase; led updates one edge after the mode register.
REQ-022 A channel entering BLINK follows the current global blink_phase; the prescaler is not restarted.

Reset
REQ-023 While rstn=0 at an edge: s1, s2, btn_db, debounce counters, press, led, prescaler and blink_phase clear to 0, and all modes go to OFF.
REQ-024 A button held through reset release is debounced from btn_db=0 and produces one press DEB_CYCLES+2 edges after release.

Configuration
REQ-025 With macro LED_BLINK_EN defined: mode sequence OFF->ON->BLINK->OFF; prescaler and blink_phase are present.
REQ-026 Without LED_BLINK_EN: mode sequence OFF->ON->OFF (toggle); BLINK is unreachable, prescaler and blink_phase are not synthesised, and BLINK_DIV is ignored.

Verification
REQ-027 NUM_CH=4, DEB_CYCLES=4: btn[0] rises before edge 0 and is held -> btn_db[0]=1 and a single press[0] pulse after edge 5; led[0]=1 after edge 7.
REQ-028 btn[1] pulse of 3 cycles (shorter than DEB_CYCLES) -> btn_db[1], press[1] and led[1] stay 0 throughout.
REQ-029 LED_BLINK_EN, BLINK_DIV=8: three accepted presses on btn[2] -> led[2] goes 1, then toggles every 8 cycles in phase with blink_phase, then holds 0.
REQ-030 all_off asserted on the same edge as a press[3] pulse with channel 3 in ON -> mode[3]=OFF, led[3]=0 one edge later; the press is not applied afterward.
REQ-031 rstn=0 for 2 cycles while channel 0 is BLINK and btn[0] is held -> all outputs 0 during reset; one press[0] after DEB_CYCLES+2 edges following release; led[0]=1.
REQ-032 LED_BLINK_EN undefined: two accepted presses on btn[0] -> led[0] goes 1 then 0; led[0] never toggles on its own.
